// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO write-side arbiter.
//   - Default sizing constants for the arbiter parameters.
//   - Arbiter FSM state encoding.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 16;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. It searches upward from the
//   requester after Last_Id, wrapping at N_REQ-1, and returns the first
//   requester that is asking.
//   Ports:
//     Req     in   N_REQ        request vector
//     Last_Id in   $clog2(N_REQ) requester served most recently
//     Valid   out  1            at least one request is present
//     Id      out  $clog2(N_REQ) selected requester
// ---------------------------------------------------------------------------
module rr_pick
    import fifo_pkg::*;
#(
    parameter  int N_REQ = N_REQ_DEF,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] Req,
    input  logic [ID_W-1:0]  Last_Id,
    output logic             Valid,
    output logic [ID_W-1:0]  Id
);

    // Offset k=N_REQ lands back on Last_Id itself, so a lone requester that
    // was just served can be granted again.
    always_comb begin
        int cand;
        Valid = 1'b0;
        Id    = '0;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(Last_Id) + k) % N_REQ;
            if (!Valid && Req[cand]) begin
                Valid = 1'b1;
                Id    = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//   Round-robin arbiter that lets N_REQ requesters share one FIFO write port.
//   A requester is granted in IDLE, then its words are accepted one per
//   cycle (stalling on Fifo_Full) until it drops Req or MAX_BURST words have
//   been written.
//   Ports:
//     Write_Clk    in   1             FIFO write clock, rising edge
//     rst_n        in   1             asynchronous active-low reset
//     Req          in   N_REQ         per-requester write request
//     Req_Data     in   N_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
//     Fifo_Full    in   1             FIFO full, blocks writes
//     Grant        out  N_REQ         registered one-hot grant
//     Ack          out  N_REQ         combinational word-accepted pulse
//     Fifo_Wr_En   out  1             registered write strobe
//     Fifo_Wr_Data out  DATA_W        registered write data
//     Busy         out  1             FSM in BURST
//     Active_Id    out  $clog2(N_REQ) index of granted requester
// ---------------------------------------------------------------------------
module fifo_write_arbiter
    import fifo_pkg::*;
#(
    parameter  int N_REQ     = N_REQ_DEF,
    parameter  int DATA_W    = DATA_W_DEF,
    parameter  int MAX_BURST = MAX_BURST_DEF,
    localparam int ID_W      = $clog2(N_REQ),
    localparam int BEAT_W    = $clog2(MAX_BURST) + 1
) (
    input  logic                    Write_Clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] Req_Data,
    input  logic                    Fifo_Full,
    output logic [N_REQ-1:0]        Grant,
    output logic [N_REQ-1:0]        Ack,
    output logic                    Fifo_Wr_En,
    output logic [DATA_W-1:0]       Fifo_Wr_Data,
    output logic                    Busy,
    output logic [ID_W-1:0]         Active_Id
);

    arb_state_e          state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ID_W-1:0]     last_id_q, last_id_d;
    logic [ID_W-1:0]     active_id_q, active_id_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic                pick_valid;
    logic [ID_W-1:0]     pick_id;
    logic                req_g;
    logic                accept;
    logic [DATA_W-1:0]   word_g;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .Req     (Req),
        .Last_Id (last_id_q),
        .Valid   (pick_valid),
        .Id      (pick_id)
    );

    // Only the granted requester matters while bursting; everyone else is
    // ignored until the burst ends.
    assign req_g  = Req[active_id_q];
    assign word_g = Req_Data[int'(active_id_q)*DATA_W +: DATA_W];
    assign accept = (state_q == BURST) && req_g && !Fifo_Full;

    // Ack reuses the registered grant, so it can never be non-zero while
    // Grant is zero.
    assign Ack          = accept ? grant_q : '0;
    assign Grant        = grant_q;
    assign Fifo_Wr_En   = wr_en_q;
    assign Fifo_Wr_Data = wr_data_q;
    assign Busy         = (state_q == BURST);
    assign Active_Id    = active_id_q;

    // Next-state logic. The write strobe defaults low so every accepted
    // word produces exactly one strobe on the following edge.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        beat_d      = beat_q;
        last_id_d   = last_id_q;
        active_id_d = active_id_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d          = BURST;
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    active_id_d      = pick_id;
                    beat_d           = '0;
                end
            end
            BURST: begin
                if (!req_g) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    last_id_d = active_id_q;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_data_d = word_g;
                    beat_d    = beat_q + BEAT_W'(1);
                    if (beat_q == BEAT_W'(MAX_BURST - 1)) begin
                        state_d   = IDLE;
                        grant_d   = '0;
                        last_id_d = active_id_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Last_Id resets to the top index so requester 0 wins the first grant.
    always_ff @(posedge Write_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            beat_q      <= '0;
            last_id_q   <= ID_W'(N_REQ - 1);
            active_id_q <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            beat_q      <= beat_d;
            last_id_q   <= last_id_d;
            active_id_q <= active_id_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
        end
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, 16, word width, matching the FIFO write bus.
REQ-003 SHALL have parameter MAX_BURST, 4, maximum words accepted per grant (1..16).
REQ-004 SHALL have port Write_Clk  input  1  FIFO write-side clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port Req  input  N_REQ  per-requester write request, held while the requester has data.
REQ-007 SHALL have port Req_Data  input  N_REQ*DATA_W  concatenated requester data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port Fifo_Full  input  1  FIFO full flag; no write may be issued while it is high.
REQ-009 SHALL have port Grant  output  N_REQ  registered one-hot grant (all-zero when idle).
REQ-010 SHALL have port Ack  output  N_REQ  combinational one-hot pulse: the granted requester's current word is accepted this cycle.
REQ-011 SHALL have port Fifo_Wr_En  output  1  registered FIFO write strobe.
REQ-012 SHALL have port Fifo_Wr_Data  output  DATA_W  registered FIFO write data.
REQ-013 SHALL have port Busy  output  1  high while in state BURST.
REQ-014 SHALL have port Active_Id  output  $clog2(N_REQ)  index of the granted requester; holds the last value when idle.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and BURST.
REQ-016 In IDLE with any Req bit high, SHALL grant round-robin, searching from (Last_Id+1) mod N_REQ upward with wrap; the grant registers on the next edge and the FSM moves to BURST with Beat=0.
REQ-017 The IDLE cycle SHALL issue no write; Fifo_Full SHALL NOT block the grant decision.
REQ-018 In BURST, accept SHALL be Req[g] & ~Fifo_Full; on accept, Ack[g]=1 that cycle and Fifo_Wr_En<=1, Fifo_Wr_Data<=word g, Beat<=Beat+1 on the next edge.
REQ-019 Fifo_Wr_En SHALL be 0 on every edge without an accept, so each word is written exactly once with 1-cycle latency from its Ack.
REQ-020 While Fifo_Full=1 in BURST, SHALL hold Grant, Beat and state with no Ack; the stall length is unbounded.
REQ-021 BURST SHALL end (Grant<=0, Last_Id<=g, state<=IDLE) when Req[g]=0, or on an accept with Beat=MAX_BURST-1.
REQ-022 At most one Ack bit and one write per cycle, and Ack SHALL be zero whenever Grant is zero.
REQ-023 Every requester continuously requesting SHALL be granted within N_REQ bursts (starvation-free).
REQ-024 Beat SHALL be $clog2(MAX_BURST)+1 bits wide with no wrap inside a burst; Last_Id SHALL wrap N_REQ-1 -> 0.
REQ-025 Requests from requesters other than g SHALL be ignored during BURST; a new Req arriving on the burst-exit edge SHALL be arbitrated in the following IDLE cycle.

Reset
REQ-026 rst_n low SHALL asynchronously force state=IDLE, Grant=0, Fifo_Wr_En=0, Fifo_Wr_Data=0, Busy=0, Beat=0, Active_Id=0, and Last_Id=N_REQ-1, so requester 0 wins first.
REQ-027 Reset mid-burst SHALL drop the in-flight word; no Fifo_Wr_En SHALL appear on the first edge after rst_n deasserts.

Structure
REQ-028 The FSM state encoding and the default constants (N_REQ, DATA_W, MAX_BURST) SHALL live in a shared package, fifo_pkg.
REQ-029 Round-robin selection SHALL be a combinational sub-module, rr_pick (inputs Req, Last_Id; outputs Valid, Id).

Verification
REQ-030 Reset, then Req=0001, Data0=0xA5A5 held 4 cycles -> Grant=0001 after 1 cycle; 4 Acks; Fifo_Wr_Data sequence 0xA5A5 x4; then Grant=0.
REQ-031 Req=1111 constant, Fifo_Full=0 -> grant order 0,1,2,3,0; each burst exactly 4 writes; 1 idle cycle between bursts.
REQ-032 Requester 2 in burst, Fifo_Full=1 for 5 cycles at Beat=2 -> no Ack or Fifo_Wr_En for 5 cycles, Grant held; 2 more words written after Fifo_Full falls.
REQ-033 Requester 1 drops Req after 2 accepted words -> burst ends, Last_Id=1, next grant goes to lowest requesting index >1 (with wrap).
REQ-034 rst_n pulsed low during the 3rd beat of a burst -> all outputs 0 asynchronously; after release, first grant goes to requester 0 and no stale write appears.
